// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready requests, big-endian byte storage, programmable wait states.
// Define DMEM_RESET_CLEAR_EN to have every reset cycle also zero the storage.
module dmem_responder #(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // resp_valid is a single-cycle pulse carrying resp_rdata/resp_err for that request.
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, next_state;

    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_be;
    logic        accept, enter_resp, do_store;
    logic        cur_we, cur_err;
    logic [31:0] cur_addr, cur_wdata, load_data;
    logic [3:0]  cur_be;
    logic [7:0]  mem [DEPTH] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (wait_cnt == 4'd0) next_state = RESP;
            RESP:    next_state = accept ? ((WAIT_CYCLES > 0) ? WAIT : RESP) : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = !rst && (state == IDLE || state == RESP);
        resp_valid = !rst && (state == RESP);
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else if (accept) begin
            wait_cnt  <= 4'(WAIT_CYCLES - 1);
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Without wait states the request being accepted is served on the same edge.
    always_comb begin
        if (state == WAIT) begin
            cur_we    = lat_we;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_be    = lat_be;
        end else begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end
    end

    assign cur_err    = cur_addr > 32'(DEPTH - 4);
    assign enter_resp = !rst && (next_state == RESP);
    assign do_store   = enter_resp && cur_we && !cur_err;

    always_comb begin
        load_data = 32'd0;
        for (int k = 0; k < 4; k++)
            load_data[31-8*k -: 8] = mem[cur_addr[AW-1:0] + AW'(k)];
    end

    always_ff @(posedge clk) begin
`ifdef DMEM_RESET_CLEAR_EN
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (do_store) begin
            for (int k = 0; k < 4; k++)
                if (cur_be[3-k]) mem[cur_addr[AW-1:0] + AW'(k)] <= cur_wdata[31-8*k -: 8];
        end
`else
        if (do_store) begin
            for (int k = 0; k < 4; k++)
                if (cur_be[3-k]) mem[cur_addr[AW-1:0] + AW'(k)] <= cur_wdata[31-8*k -: 8];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_err   <= cur_err;
            resp_rdata <= (cur_err || cur_we) ? 32'd0 : load_data;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait and a three-wait instance share one request bus selected by sel.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        ready0, ready3, rv0, rv3, err0, err3;
    logic [31:0] rd0, rd3;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    dmem_responder #(.DEPTH(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0)
    );

    dmem_responder #(.DEPTH(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(ready3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3)
    );

    assign req_ready  = sel ? ready3 : ready0;
    assign resp_valid = sel ? rv3 : rv0;
    assign resp_rdata = sel ? rd3 : rd0;
    assign resp_err   = sel ? err3 : err0;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  model [2][32];

    // Reference memory: returns {err, rdata} and applies stores.
    function automatic logic [32:0] model_access(input logic s, input logic we,
                                                 input logic [31:0] addr, input logic [31:0] wdata,
                                                 input logic [3:0] be);
        logic [31:0] rd;
        rd = 32'd0;
        if (addr > 32'd28) return {1'b1, 32'd0};
        for (int k = 0; k < 4; k++) begin
            if (we && be[3-k]) model[s][int'(addr[4:0]) + k] = wdata[31-8*k -: 8];
            if (!we) rd[31-8*k -: 8] = model[s][int'(addr[4:0]) + k];
        end
        return {1'b0, we ? 32'd0 : rd};
    endfunction

    function automatic void model_reset();
`ifdef DMEM_RESET_CLEAR_EN
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++) model[s][i] = 8'h00;
`endif
    endfunction

    // Called at a negedge; returns 1ns after the accepting edge with req_valid dropped.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int n);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic await_resp(output logic got, output logic [32:0] obs, output int cyc);
        got = 1'b0; obs = '0; cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                got = 1'b1;
                obs = {resp_err, resp_rdata};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready0, ready3, rv0, rv3} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: ready0/3,rv0/3=%b, required 0000", {ready0, ready3, rv0, rv3});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready0, ready3, rv0, rv3} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release: ready0/3,rv0/3=%b, required 1100", {ready0, ready3, rv0, rv3});
        end
        checks++;
        if ({err0, rd0, err3, rd3} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs: rd0=%08h err0=%b rd3=%08h err3=%b, required zeros", rd0, err0, rd3, err3);
        end
    endtask

    task automatic test_store_load();
        logic        we_t   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] addr_t [6] = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd12, 32'd12};
        logic [31:0] wd_t   [6] = '{32'hDEADBEEF, 32'h0, 32'h11223344, 32'h0, 32'hA1B2C3D4, 32'h0};
        logic [3:0]  be_t   [6] = '{4'b1111, 4'b0000, 4'b0101, 4'b1111, 4'b1111, 4'b0000};
        logic [32:0] exp_t  [6] = '{33'h0, {1'b0, 32'hDEADBEEF}, 33'h0, {1'b0, 32'hDE22BE44},
                                    33'h0, {1'b0, 32'hA1B2C3D4}};
        logic got; logic [32:0] obs, exp; int cyc, n;
        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            void'(model_access(1'b0, we_t[i], addr_t[i], wd_t[i], be_t[i]));
            exp_q.push_back(exp_t[i]);
            do_req(we_t[i], addr_t[i], wd_t[i], be_t[i], n);
            await_resp(got, obs, cyc);
            checks++;
            if (!got || cyc != 1) begin
                errors++;
                $display("FAIL store_load_latency[%0d]: got=%b cycles=%0d, required 1 cycle", i, got, cyc);
            end
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL store_load_data[%0d]: err=%b rdata=%08h, required err=%b rdata=%08h",
                         i, obs[32], obs[31:0], exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_range();
        logic        we_t   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] addr_t [6] = '{32'd5, 32'd29, 32'hFFFFFFFE, 32'd4, 32'd28, 32'h80000004};
        logic [32:0] exp_t  [6] = '{{1'b0, 32'h22BE4400}, {1'b1, 32'h0}, {1'b1, 32'h0},
                                    {1'b0, 32'hDE22BE44}, 33'h0, {1'b1, 32'h0}};
        logic got; logic [32:0] obs, exp; int cyc, n;
        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            void'(model_access(1'b0, we_t[i], addr_t[i], 32'h55667788, 4'b1111));
            exp_q.push_back(exp_t[i]);
            do_req(we_t[i], addr_t[i], 32'h55667788, 4'b1111, n);
            await_resp(got, obs, cyc);
            exp = exp_q.pop_front();
            checks++;
            if (!got || obs !== exp) begin
                errors++;
                $display("FAIL range[%0d]: got=%b err=%b rdata=%08h, required err=%b rdata=%08h",
                         i, got, obs[32], obs[31:0], exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic got; logic [32:0] obs, exp; int cyc, n;
        logic we; logic [31:0] addr, wdata; logic [3:0] be;
        sel = 1'b0;
        for (int i = 0; i < 24; i++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            exp_q.push_back(model_access(1'b0, we, addr, wdata, be));
            do_req(we, addr, wdata, be, n);
            checks++;
            if (n != 0) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: waited %0d cycles, required 0", i, n);
            end
            await_resp(got, obs, cyc);
            exp = exp_q.pop_front();
            checks++;
            if (!got || cyc != 1 || obs !== exp) begin
                errors++;
                $display("FAIL b2b[%0d]: got=%b cyc=%0d err=%b rdata=%08h, required cyc=1 err=%b rdata=%08h",
                         i, got, cyc, obs[32], obs[31:0], exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_reset_persist();
        logic got; logic [32:0] obs, exp; int cyc, n;
        sel = 1'b0;
        void'(model_access(1'b0, 1'b1, 32'd8, 32'h12345678, 4'b1111));
        do_req(1'b1, 32'd8, 32'h12345678, 4'b1111, n);
        await_resp(got, obs, cyc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
`ifdef DMEM_RESET_CLEAR_EN
        exp_q.push_back(33'h0);
`else
        exp_q.push_back({1'b0, 32'h12345678});
`endif
        void'(model_access(1'b0, 1'b0, 32'd8, 32'h0, 4'b0000));
        do_req(1'b0, 32'd8, 32'h0, 4'b0000, n);
        await_resp(got, obs, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("FAIL reset_persist: got=%b rdata=%08h, required rdata=%08h", got, obs[31:0], exp[31:0]);
        end
    endtask

    task automatic test_wait_latency();
        logic got; logic [32:0] obs, exp; int cyc, n;
        sel = 1'b1;
        void'(model_access(1'b1, 1'b1, 32'd16, 32'hCAFEF00D, 4'b1111));
        exp_q.push_back(33'h0);
        do_req(1'b1, 32'd16, 32'hCAFEF00D, 4'b1111, n);
        await_resp(got, obs, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (!got || cyc != 4 || obs !== exp) begin
            errors++;
            $display("FAIL wait_store: got=%b cyc=%0d err=%b, required cyc=4 err=0", got, cyc, obs[32]);
        end
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        do_req(1'b0, 32'd16, 32'h0, 4'b0000, n);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_cycle[%0d]: ready=%b valid=%b, required 0 0", c, req_ready, resp_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_resp_cycle: ready=%b valid=%b, required 1 1", req_ready, resp_valid);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({resp_err, resp_rdata} !== exp) begin
            errors++;
            $display("FAIL wait_load: err=%b rdata=%08h, required err=%b rdata=%08h",
                     resp_err, resp_rdata, exp[32], exp[31:0]);
        end
        exp_q.push_back({1'b0, 32'hFEF00D00});
        do_req(1'b0, 32'd17, 32'h0, 4'b0000, n);
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL wait_b2b_accept: waited %0d cycles, required 0", n);
        end
        await_resp(got, obs, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (!got || cyc != 4 || obs !== exp) begin
            errors++;
            $display("FAIL wait_b2b_load: got=%b cyc=%0d rdata=%08h, required cyc=4 rdata=%08h",
                     got, cyc, obs[31:0], exp[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic got; logic [32:0] obs, exp; int cyc, n, seen;
        sel = 1'b1;
        do_req(1'b1, 32'd0, 32'hAABBCCDD, 4'b1111, n);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rv0 || rv3) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_valid: resp_valid seen %0d times, required 0", seen);
        end
        exp_q.push_back(model_access(1'b1, 1'b0, 32'd0, 32'h0, 4'b0000));
        do_req(1'b0, 32'd0, 32'h0, 4'b0000, n);
        await_resp(got, obs, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (!got || obs !== {1'b0, 32'h00000000} || obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_load: got=%b rdata=%08h, required rdata=00000000", got, obs[31:0]);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        sel = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++) model[s][i] = 8'h00;
        test_reset();
        test_store_load();
        test_range();
        test_back_to_back();
        test_reset_persist();
        test_wait_latency();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
